// File: rtl/stream_to_axi_r_if.sv
// Bus bundle for stream_to_axi_r.
//  Stream side : can_forwardR, input_valid, input_data -> input_ready
//  R side      : AXIS_rid/rdata/rresp/rlast/ruser/rvalid -> AXIS_rready
//  Status      : type_err, len_err, err_count
// modport slave  : the stream_to_axi_r block itself.
// modport master : the environment, which feeds the stream and consumes R beats.
interface stream_to_axi_r_if #(
  parameter int DATA_WIDTH    = 128,
  parameter int ID_WIDTH      = 32,
  parameter int USER_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     can_forwardR;
  logic                     input_valid;
  logic [DATA_WIDTH-1:0]    input_data;
  logic                     input_ready;
  logic [ID_WIDTH-1:0]      AXIS_rid;
  logic [DATA_WIDTH-1:0]    AXIS_rdata;
  logic [1:0]               AXIS_rresp;
  logic                     AXIS_rlast;
  logic [USER_WIDTH-1:0]    AXIS_ruser;
  logic                     AXIS_rvalid;
  logic                     AXIS_rready;
  logic                     type_err;
  logic                     len_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output can_forwardR, input_valid, input_data, AXIS_rready,
    input  input_ready, AXIS_rid, AXIS_rdata, AXIS_rresp, AXIS_rlast, AXIS_ruser,
           AXIS_rvalid, type_err, len_err, err_count
  );

  modport slave (
    input  can_forwardR, input_valid, input_data, AXIS_rready,
    output input_ready, AXIS_rid, AXIS_rdata, AXIS_rresp, AXIS_rlast, AXIS_ruser,
           AXIS_rvalid, type_err, len_err, err_count
  );
endinterface

// File: rtl/stream_to_axi_r.sv
// stream_to_axi_r: far end of the R-channel stream link. Consumes word pairs
// (data word, then metadata word), checks the metadata type tag and rebuilds
// one AXI R beat per good pair. Tracks burst position to flag bursts that run
// to BURST_LEN beats without RLAST, and keeps a saturating error count.
// Ports:
//  clk   - clock, rising edge
//  reset - asynchronous, active-high
//  bus   - stream_to_axi_r_if.slave (stream in, R beat out, error status)
// Metadata word (LSB up): [1:0] rresp, [2] rlast, [ID_WIDTH+2:3] rid,
//  then USER_WIDTH bits ruser, type tag in the top STREAM_TYPE_WIDTH bits.
// Interface parameters must match the ones given here.
module stream_to_axi_r #(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           BURST_LEN         = 8,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = '0,
  parameter int                           ERR_CNT_WIDTH     = 8
) (
  input logic               clk,
  input logic               reset,
  stream_to_axi_r_if.slave  bus
);
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int ID_LSB   = 3;
  localparam int USER_LSB = 3 + ID_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  generate
    if (3 + ID_WIDTH + USER_WIDTH + STREAM_TYPE_WIDTH > DATA_WIDTH) begin : g_bad_layout
      $error("stream_to_axi_r: metadata fields do not fit in DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_META = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [ID_WIDTH-1:0]      rid_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [1:0]               rresp_q;
  logic                     rlast_q;
  logic [USER_WIDTH-1:0]    ruser_q;
  logic                     rvalid_q;
  logic                     type_err_q;
  logic                     len_err_q;
  logic [CNT_W-1:0]         beat_cnt_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic                     ready;
  logic                     accept;
  logic                     tag_ok;

  // Ready is held low through reset so nothing is taken while the FSM is held.
  assign ready  = !reset && bus.can_forwardR && (state_q != S_SEND);
  assign accept = bus.input_valid && ready;
  assign tag_ok = (bus.input_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] == STREAM_TYPE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_DATA;
      data_q     <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      ruser_q    <= '0;
      rvalid_q   <= 1'b0;
      type_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      type_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      case (state_q)
        S_DATA: begin
          if (accept) begin
            data_q  <= bus.input_data;
            state_q <= S_META;
          end
        end
        S_META: begin
          if (accept) begin
            if (tag_ok) begin
              rdata_q  <= data_q;
              rresp_q  <= bus.input_data[1:0];
              rlast_q  <= bus.input_data[2];
              rid_q    <= bus.input_data[ID_LSB +: ID_WIDTH];
              ruser_q  <= bus.input_data[USER_LSB +: USER_WIDTH];
              rvalid_q <= 1'b1;
              state_q  <= S_SEND;
            end else begin
              // Bad tag: the whole pair is discarded.
              type_err_q <= 1'b1;
              if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
              state_q    <= S_DATA;
            end
          end
        end
        S_SEND: begin
          // rvalid is always high here, so rready alone completes the beat.
          if (bus.AXIS_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= S_DATA;
            if (rlast_q) begin
              beat_cnt_q <= '0;
            end else if (beat_cnt_q == CNT_MAX) begin
              // Burst reached max length with no RLAST; beat still goes out.
              len_err_q  <= 1'b1;
              if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

  assign bus.input_ready = ready;
  assign bus.AXIS_rid    = rid_q;
  assign bus.AXIS_rdata  = rdata_q;
  assign bus.AXIS_rresp  = rresp_q;
  assign bus.AXIS_rlast  = rlast_q;
  assign bus.AXIS_ruser  = ruser_q;
  assign bus.AXIS_rvalid = rvalid_q;
  assign bus.type_err    = type_err_q;
  assign bus.len_err     = len_err_q;
  assign bus.err_count   = err_cnt_q;
endmodule

// File: tb/tb_stream_to_axi_r.sv
// Bench for stream_to_axi_r: directed scenarios plus randomized pair traffic,
// checked every cycle against a transaction-level model of the link.
module tb_stream_to_axi_r;
  localparam int DW = 128;
  localparam int IW = 32;
  localparam int UW = 64;
  localparam int BL = 8;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_to_axi_r_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .ERR_CNT_WIDTH(EW)) bus ();

  stream_to_axi_r #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .BURST_LEN(BL),
    .STREAM_TYPE_WIDTH(3), .STREAM_TYPE(3'b000), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int rr_mode = 0;  // 0: rready high, 1: random, 2: rready low

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_meta(input logic [2:0] tag, input logic [IW-1:0] rid,
                                            input logic [UW-1:0] user, input logic [1:0] resp,
                                            input logic last);
    logic [DW-1:0] m;
    m = {$urandom, $urandom, $urandom, $urandom};  // don't-care bits get garbage
    m[1:0]     = resp;
    m[2]       = last;
    m[34:3]    = rid;
    m[98:35]   = user;
    m[127:125] = tag;
    return m;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model + compare process ----------------
  // The link carries (data, meta) pairs; a good pair becomes exactly one
  // outstanding beat which blocks the stream until it is taken.
  bit            m_have_data = 0;
  logic [DW-1:0] m_data;
  bit            m_pend = 0;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_resp;
  logic          m_last;
  logic [UW-1:0] m_user;
  int            m_burst = 0;  // beats of current burst already delivered
  int            m_errs  = 0;
  bit            m_terr  = 0;
  bit            m_lerr  = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_ready",  bus.input_ready, 0);
      chk("rst_rvalid", bus.AXIS_rvalid, 0);
      chk("rst_rdata",  bus.AXIS_rdata,  0);
      chk("rst_rid",    bus.AXIS_rid,    0);
      chk("rst_errcnt", bus.err_count,   0);
      chk("rst_terr",   bus.type_err,    0);
      chk("rst_lerr",   bus.len_err,     0);
      m_have_data = 0; m_pend = 0; m_burst = 0; m_errs = 0; m_terr = 0; m_lerr = 0;
    end else begin
      chk("input_ready", bus.input_ready, bus.can_forwardR && !m_pend);
      chk("rvalid",      bus.AXIS_rvalid, m_pend);
      if (m_pend) begin
        chk("rid",   bus.AXIS_rid,   m_rid);
        chk("rdata", bus.AXIS_rdata, m_rdata);
        chk("rresp", bus.AXIS_rresp, m_resp);
        chk("rlast", bus.AXIS_rlast, m_last);
        chk("ruser", bus.AXIS_ruser, m_user);
      end
      chk("type_err",  bus.type_err,  m_terr);
      chk("len_err",   bus.len_err,   m_lerr);
      chk("err_count", bus.err_count, m_errs);
      // advance model by the upcoming rising edge
      m_terr = 0; m_lerr = 0;
      if (m_pend) begin
        if (bus.AXIS_rready) begin
          m_pend = 0;
          if (m_last) m_burst = 0;
          else begin
            m_burst++;
            if (m_burst == BL) begin
              m_lerr = 1; m_burst = 0;
              if (m_errs < 255) m_errs++;
            end
          end
        end
      end else if (bus.input_valid && bus.can_forwardR) begin
        if (!m_have_data) begin
          m_data = bus.input_data; m_have_data = 1;
        end else begin
          m_have_data = 0;
          if (bus.input_data[127:125] == 3'b000) begin
            m_pend  = 1;
            m_rdata = m_data;
            m_resp  = bus.input_data[1:0];
            m_last  = bus.input_data[2];
            m_rid   = bus.input_data[34:3];
            m_user  = bus.input_data[98:35];
          end else begin
            m_terr = 1;
            if (m_errs < 255) m_errs++;
          end
        end
      end
    end
  end

  // ---------------- rready driver ----------------
  initial begin
    bus.AXIS_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.AXIS_rready = 1'b1;
        1:       bus.AXIS_rready = 1'($urandom_range(0, 1));
        default: bus.AXIS_rready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a word until accepted; returns just after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, input bit rnd_can);
    int  n = 0;
    bit  done = 0;
    bus.input_data  = w;
    bus.input_valid = 1'b1;
    while (!done) begin
      if (rnd_can) bus.can_forwardR = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = bus.input_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
    end
    bus.input_valid = 1'b0;
    bus.input_data  = rnd128();
  endtask

  task automatic send_pair(input logic [DW-1:0] d, input logic [DW-1:0] m, input bit rnd_can);
    send_word(d, rnd_can);
    send_word(m, rnd_can);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (bus.AXIS_rvalid && n < 200) begin @(negedge clk); n++; end
    chk("drain_rvalid", bus.AXIS_rvalid, 0);
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] a5;

  initial begin
    bus.can_forwardR = 1'b1;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    a5 = {16{8'hA5}};
    idle(3);
    reset = 1'b0;
    idle(1);

    // basic beat, rvalid one cycle after metadata accept
    rr_mode = 0;
    send_pair(a5, mk_meta(3'b000, 32'd7, 64'h0, 2'b00, 1'b1), 0);
    @(negedge clk);
    chk("t2_rvalid", bus.AXIS_rvalid, 1);
    chk("t2_rdata",  bus.AXIS_rdata,  a5);
    chk("t2_rid",    bus.AXIS_rid,    7);
    chk("t2_rlast",  bus.AXIS_rlast,  1);
    @(posedge clk); #1;
    drain();

    // backpressure: beat held for 5 cycles, stream blocked
    rr_mode = 2;
    send_pair(a5, mk_meta(3'b000, 32'd7, 64'h1234, 2'b10, 1'b1), 0);
    bus.input_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_ready_low", bus.input_ready, 0);
      chk("t3_rdata",     bus.AXIS_rdata,  a5);
      @(posedge clk); #1;
    end
    bus.input_valid = 1'b0;
    rr_mode = 0;
    drain();

    // bad tag: dropped, counted, next pair fine
    send_pair(rnd128(), mk_meta(3'b101, 32'd3, 64'h0, 2'b00, 1'b1), 0);
    @(negedge clk);
    chk("t4_type_err", bus.type_err,    1);
    chk("t4_rvalid",   bus.AXIS_rvalid, 0);
    @(posedge clk); #1;
    idle(1);
    @(negedge clk);
    chk("t4_errcnt", bus.err_count, 1);
    @(posedge clk); #1;
    send_pair(rnd128(), mk_meta(3'b000, 32'd9, 64'h5, 2'b01, 1'b1), 0);
    drain();

    // burst overrun: 8 beats without rlast, then a clean 4-beat burst
    for (int i = 0; i < 8; i++) begin
      send_pair(rnd128(), mk_meta(3'b000, 32'(i), 64'(i), 2'b00, 1'b0), 0);
      drain();
    end
    @(negedge clk);
    chk("t5_errcnt", bus.err_count, 2);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send_pair(rnd128(), mk_meta(3'b000, 32'd1, 64'h0, 2'b00, 1'(i == 3)), 0);
      drain();
    end
    idle(1);
    @(negedge clk);
    chk("t5_errcnt_clean", bus.err_count, 2);
    @(posedge clk); #1;

    // enable low blocks accepts; dropping it in send state doesn't abort the beat
    bus.can_forwardR = 1'b0;
    bus.input_valid  = 1'b1;
    bus.input_data   = rnd128();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_ready_off", bus.input_ready, 0);
      @(posedge clk); #1;
    end
    bus.input_valid  = 1'b0;
    bus.can_forwardR = 1'b1;
    rr_mode = 2;
    send_pair(rnd128(), mk_meta(3'b000, 32'd2, 64'h0, 2'b11, 1'b1), 0);
    bus.can_forwardR = 1'b0;
    idle(3);
    rr_mode = 0;
    idle(3);
    @(negedge clk);
    chk("t6_beat_done", bus.AXIS_rvalid, 0);
    @(posedge clk); #1;
    bus.can_forwardR = 1'b1;

    // reset while a beat is pending
    rr_mode = 2;
    send_pair(a5, mk_meta(3'b000, 32'd4, 64'h0, 2'b00, 1'b1), 0);
    @(negedge clk);
    chk("t1_pending", bus.AXIS_rvalid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t1_rvalid_drop", bus.AXIS_rvalid, 0);
    chk("t1_ready_rst",   bus.input_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rr_mode = 0;
    @(negedge clk);
    chk("t1_errcnt", bus.err_count, 0);
    chk("t1_ready",  bus.input_ready, 1);
    @(posedge clk); #1;

    // randomized traffic
    rr_mode = 1;
    for (int p = 0; p < 300; p++) begin
      logic [2:0] tag;
      idle($urandom_range(0, 2));
      tag = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      send_pair(rnd128(),
                mk_meta(tag, $urandom, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 3) == 0)), 1);
    end
    bus.can_forwardR = 1'b1;
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
